keypad_entry: RTL and testbench
===============================

# keypad_entry

Scans a 4x4 matrix keypad and assembles the user's two-digit charge amount (0–99) as binary money. It is the input counterpart of the digit-multiplexed display path: the display drives one-hot digit strobes out, and this block drives one-hot column strobes and reads the rows back. A confirmed amount is handed to the billing logic over a valid/ack handshake. The in-progress entry is exported with the same 8'hFF blank sentinel the display path uses.

## Interface
- SCAN_DIV, 1000: clock cycles each column stays strobed (≥2).
- DEBOUNCE_CNT, 3: consecutive identical scan frames required to accept a press or a release (≥1).
- TIMEOUT, 50_000_000: idle cycles before a partial entry is discarded; used only with KEYPAD_TIMEOUT_EN.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- row  in  4  keypad rows, active-high, asynchronous; 2-flop synchronised internally.
- col  out  4  one-hot column strobe.
- money_out  out  8  last confirmed amount, binary.
- money_valid  out  1  confirmed amount pending.
- money_ack  in  1  consumer accepts money_out.
- entry  out  8  amount being typed, binary; 8'hFF means blank.

## Operation
- Reset values:
  - col = 4'b0001
  - money_out = 8'hFF
  - money_valid = 0
  - entry = 8'hFF
  - FSM = EMPTY
- Scan:
  - col rotates 0001→0010→0100→1000→0001, one step every SCAN_DIV cycles.
  - Synchronised row is sampled on the last dwell cycle of each column.
  - Four columns make one frame.
- Key map (row r, column c):
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = * 0 # D
- Frame key:
  - Exactly one closed contact in the frame gives that key.
  - Zero contacts, or two or more, give NONE.
- Debounce:
  - A frame key equal to the previous one increments a saturating count; a different key sets the count to 1.
  - A press event fires once, when the count reaches DEBOUNCE_CNT with key ≠ NONE and the block is armed. Firing disarms.
  - Count reaching DEBOUNCE_CNT with NONE re-arms.
  - A held key therefore never repeats.
- FSM:
  - EMPTY:
    - Digit d: value = d, go to ONE.
    - A, B, C, D, *, #: ignored.
  - ONE:
    - Digit d: value = value*10 + d, go to TWO.
    - A: load money_out = value, set money_valid = 1, go to WAIT_ACK.
    - B: go to EMPTY.
  - TWO:
    - Digits: ignored.
    - A and B: same as in ONE.
  - WAIT_ACK:
    - All keys ignored.
    - When money_ack = 1: clear money_valid, go to EMPTY.
  - C, D, * and # are ignored in every state.
- entry = value in ONE and TWO; 8'hFF in EMPTY and WAIT_ACK.
- money_out holds its value after ack until the next confirm.
- Arithmetic: value*10 + d fits in 7 bits. Maximum entry is 99; leading zeros are allowed ("0","5" gives 5).
- money_ack outside WAIT_ACK has no effect.
- If a press event and money_ack arrive in the same cycle in WAIT_ACK, the ack is taken and the key is dropped.

## Timing
- The frame key is registered on the cycle the 1000 column dwell ends.
- The press event is asserted for 1 cycle, on the cycle after the frame that reaches DEBOUNCE_CNT.
- FSM state, entry, money_out and money_valid update on the cycle after the press event.
- Minimum latency from a stable press to entry change is (DEBOUNCE_CNT × 4 × SCAN_DIV) + 4 cycles.
- money_valid is level, held until the first CLK edge with money_ack = 1. It falls on the cycle after that edge.
- Reset mid-operation immediately forces all reset values. The scan restarts at column 0, and debounce count and arm state clear (armed, count 0).

## Configuration
- KEYPAD_TIMEOUT_EN defined:
  - In ONE and TWO, a counter clears on every accepted press event.
  - After TIMEOUT cycles without one, the FSM goes to EMPTY and entry becomes 8'hFF.
  - The counter is idle in EMPTY and WAIT_ACK.
- Not defined: no counter is built, TIMEOUT is ignored, and partial entries persist indefinitely.

## Structure
- Package keypad_pkg holds:
  - the FSM state enum EMPTY/ONE/TWO/WAIT_ACK
  - 4-bit key codes 0–9, KEY_CONFIRM = 4'hA, KEY_CLEAR = 4'hB, KEY_NONE = 4'hF
  - constant BLANK = 8'hFF
  - the row/column-to-key lookup function
- Sub-module keypad_debounce takes the frame key plus a frame strobe and outputs the press event and key code. It owns the count and the arm flag.
- Scan counter and entry FSM stay in keypad_entry.

## Test plan
- Bench parameters: SCAN_DIV = 4, DEBOUNCE_CNT = 2.
- Press 4 then 2 then A, each held 3 frames and released 3 frames → entry goes FF→04→2A (42). money_out = 8'h2A, money_valid = 1, entry = FF. Pulse money_ack → money_valid = 0.
- Hold key 7 for 20 frames → exactly one event; entry = 07.
- 1 frame of key 5 between NONE frames, plus simultaneous 1 and 2 for 5 frames → no event; entry stays FF.
- Digits 9, 9, 3 then A → entry 63 after the second digit, the third digit is ignored, money_out = 8'h63. Pressing B after one digit → entry FF.
- In WAIT_ACK, press 8, then ack in the same cycle as the event → key dropped, state EMPTY. Assert RST_N low mid-entry → col = 0001, money_out = FF, entry = FF.
- With KEYPAD_TIMEOUT_EN and TIMEOUT = 100 → entry 03 returns to FF about 100 cycles after the press event. Without the macro, it stays 03.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key codes and the keypad matrix lookup for keypad_entry.
package keypad_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO, WAIT_ACK} state_t;

    localparam logic [3:0] KEY_CONFIRM = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;
    // '*' and '#' share one code: both are ignored everywhere.
    localparam logic [3:0] KEY_STAR    = 4'hE;
    localparam logic [3:0] KEY_NONE    = 4'hF;
    localparam logic [7:0] BLANK       = 8'hFF;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = KEY_NONE;
        unique case ({r, c})
            4'b0000: k = 4'h1;
            4'b0001: k = 4'h2;
            4'b0010: k = 4'h3;
            4'b0011: k = KEY_CONFIRM;
            4'b0100: k = 4'h4;
            4'b0101: k = 4'h5;
            4'b0110: k = 4'h6;
            4'b0111: k = KEY_CLEAR;
            4'b1000: k = 4'h7;
            4'b1001: k = 4'h8;
            4'b1010: k = 4'h9;
            4'b1011: k = 4'hC;
            4'b1100: k = KEY_STAR;
            4'b1101: k = 4'h0;
            4'b1110: k = KEY_STAR;
            4'b1111: k = 4'hD;
        endcase
        return k;
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: turns per-frame key codes into single press events.
// A key must persist DEBOUNCE_CNT frames to fire; NONE for DEBOUNCE_CNT frames re-arms.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] frame_key,
    input  logic       frame_strobe,
    output logic       press,
    output logic [3:0] press_key
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]       prev_key;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             armed;

    // Saturating run-length of identical frame keys.
    always_comb begin
        cnt_next = cnt;
        if (frame_key != prev_key) begin
            cnt_next = CNT_W'(1);
        end else if (cnt != CNT_W'(DEBOUNCE_CNT)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Run-length tracking, arm flag and the one-cycle press event.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_key  <= KEY_NONE;
            cnt       <= '0;
            armed     <= 1'b1;
            press     <= 1'b0;
            press_key <= KEY_NONE;
        end else begin
            press <= 1'b0;
            if (frame_strobe) begin
                prev_key <= frame_key;
                cnt      <= cnt_next;
                if (cnt_next == CNT_W'(DEBOUNCE_CNT)) begin
                    if (frame_key == KEY_NONE) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        press     <= 1'b1;
                        press_key <= frame_key;
                        armed     <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scanner and two-digit amount entry with valid/ack hand-off.
// Optional feature macro: KEYPAD_TIMEOUT_EN (discard partial entries after TIMEOUT idle cycles).
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 3,
    parameter int unsigned TIMEOUT      = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] money_out,
    output logic       money_valid,
    input  logic       money_ack,
    output logic [7:0] entry
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [11:0]      frame_bits;
    logic [15:0]      frame_vec;
    logic [3:0]       frame_dec;
    logic [3:0]       frame_key;
    logic             frame_strobe;
    logic             dwell_end;
    logic             press;
    logic [3:0]       press_key;
    state_t           state;
    logic [6:0]       value;
    logic [6:0]       value_next;

    assign dwell_end  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    // Columns 0..2 come from the stored samples; column 3 is being sampled now.
    assign frame_vec  = {row_sync, frame_bits};
    assign value_next = value * 7'd10 + {3'b000, press_key};

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta <= 4'b0;
            row_sync <= 4'b0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Frame key: exactly one closed contact names a key, otherwise NONE.
    always_comb begin
        logic [4:0] hits;
        logic [3:0] found;
        hits  = 5'd0;
        found = KEY_NONE;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (frame_vec[c*4 + r]) begin
                    hits  = hits + 5'd1;
                    found = key_lookup(2'(r), 2'(c));
                end
            end
        end
        frame_dec = (hits == 5'd1) ? found : KEY_NONE;
    end

    // Column rotation, per-column row sampling and frame key registration.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt      <= '0;
            col_idx      <= 2'd0;
            col          <= 4'b0001;
            frame_bits   <= 12'b0;
            frame_key    <= KEY_NONE;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (dwell_end) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                col     <= {col[2:0], col[3]};
                unique case (col_idx)
                    2'd0: frame_bits[3:0]  <= row_sync;
                    2'd1: frame_bits[7:4]  <= row_sync;
                    2'd2: frame_bits[11:8] <= row_sync;
                    2'd3: begin
                        frame_key    <= frame_dec;
                        frame_strobe <= 1'b1;
                    end
                endcase
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .frame_key   (frame_key),
        .frame_strobe(frame_strobe),
        .press       (press),
        .press_key   (press_key)
    );

`ifdef KEYPAD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_expired;

    assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Idle counter, running only while a partial entry is held.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if ((state != ONE && state != TWO) || press || tmo_expired) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // Entry FSM with registered entry/money outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= EMPTY;
            value       <= 7'd0;
            money_out   <= BLANK;
            money_valid <= 1'b0;
            entry       <= BLANK;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (press && is_digit(press_key)) begin
                        value <= {3'b000, press_key};
                        entry <= {4'b0000, press_key};
                        state <= ONE;
                    end
                end
                ONE, TWO: begin
                    if (press) begin
                        if (is_digit(press_key)) begin
                            if (state == ONE) begin
                                value <= value_next;
                                entry <= {1'b0, value_next};
                                state <= TWO;
                            end
                        end else if (press_key == KEY_CONFIRM) begin
                            money_out   <= {1'b0, value};
                            money_valid <= 1'b1;
                            entry       <= BLANK;
                            state       <= WAIT_ACK;
                        end else if (press_key == KEY_CLEAR) begin
                            entry <= BLANK;
                            state <= EMPTY;
                        end
                    end
`ifdef KEYPAD_TIMEOUT_EN
                    else if (tmo_expired) begin
                        entry <= BLANK;
                        state <= EMPTY;
                    end
`endif
                end
                WAIT_ACK: begin
                    // Ack wins over any key event arriving in the same cycle.
                    if (money_ack) begin
                        money_valid <= 1'b0;
                        state       <= EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: table-driven, hand-written and randomized checks of keypad_entry.
module tb_keypad_entry;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] money_out;
    logic       money_valid;
    logic       money_ack;
    logic [7:0] entry;
    logic [15:0] mask;   // pressed keys, bit r*4+c

    int checks = 0;
    int errors = 0;

    keypad_entry #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(2),
        .TIMEOUT     (100)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .row        (row),
        .col        (col),
        .money_out  (money_out),
        .money_valid(money_valid),
        .money_ack  (money_ack),
        .entry      (entry)
    );

    always #5 CLK = ~CLK;

    // Physical keypad: a closed contact connects the strobed column to its row.
    always_comb begin
        row = 4'b0;
        for (int c = 0; c < 4; c++) begin
            if (col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (mask[r*4 + c]) row[r] = 1'b1;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Key code (0-9, 10=A, 11=B, 12=C, 13=D, 14=*, 15=#) to contact mask.
    function automatic logic [15:0] kmask(input int k);
        int pos;
        case (k)
            1: pos = 0;   2: pos = 1;   3: pos = 2;   10: pos = 3;
            4: pos = 4;   5: pos = 5;   6: pos = 6;   11: pos = 7;
            7: pos = 8;   8: pos = 9;   9: pos = 10;  12: pos = 11;
            14: pos = 12; 0: pos = 13;  15: pos = 14; 13: pos = 15;
            default: pos = 0;
        endcase
        return 16'h1 << pos;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for the column strobe to wrap 1000 -> 0001 (start of a frame).
    task automatic align();
        logic [3:0] last;
        int n;
        last = col;
        n = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (last == 4'b1000 && col == 4'b0001) break;
            last = col;
            n++;
            if (n > 64) begin
                checks++;
                errors++;
                $display("FAIL align: col stuck at %b", col);
                break;
            end
        end
    endtask

    // Press for 40 cycles (2.5 frames), release for 36, frame-aligned.
    task automatic tap_key(input int k);
        align();
        mask = kmask(k);
        repeat (40) @(posedge CLK);
        #1 mask = 16'h0;
        repeat (36) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_ack();
        money_ack = 1'b1;
        @(posedge CLK);
        #1 money_ack = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // Reference model: typed digits plus a pending-confirm flag.
    int          m_digits[$];
    bit          m_wait;
    logic [7:0]  m_money;

    function automatic logic [7:0] m_entry();
        if (m_wait || m_digits.size() == 0) return 8'hFF;
        if (m_digits.size() == 1) return 8'(m_digits[0]);
        return 8'(m_digits[0] * 10 + m_digits[1]);
    endfunction

    task automatic m_press(input int k);
        if (m_wait) return;
        if (k <= 9) begin
            if (m_digits.size() < 2) m_digits.push_back(k);
        end else if (k == 10) begin
            if (m_digits.size() > 0) begin
                m_money = m_entry();
                m_wait  = 1'b1;
                m_digits.delete();
            end
        end else if (k == 11) begin
            m_digits.delete();
        end
    endtask

    task automatic m_ack();
        if (m_wait) begin
            m_wait = 1'b0;
            m_digits.delete();
        end
    endtask

    typedef struct {
        int         key;     // -1: pulse money_ack instead of pressing
        logic [7:0] e_entry;
        logic       e_valid;
        logic [7:0] e_money;
    } vec_t;

    vec_t vecs[21];

    initial begin
        bit got;
        int k;

        vecs[0]  = '{4,  8'h04, 1'b0, 8'hFF};
        vecs[1]  = '{2,  8'h2A, 1'b0, 8'hFF};
        vecs[2]  = '{10, 8'hFF, 1'b1, 8'h2A};
        vecs[3]  = '{-1, 8'hFF, 1'b0, 8'h2A};
        vecs[4]  = '{9,  8'h09, 1'b0, 8'h2A};
        vecs[5]  = '{9,  8'h63, 1'b0, 8'h2A};
        vecs[6]  = '{3,  8'h63, 1'b0, 8'h2A};
        vecs[7]  = '{10, 8'hFF, 1'b1, 8'h63};
        vecs[8]  = '{5,  8'hFF, 1'b1, 8'h63};
        vecs[9]  = '{-1, 8'hFF, 1'b0, 8'h63};
        vecs[10] = '{5,  8'h05, 1'b0, 8'h63};
        vecs[11] = '{11, 8'hFF, 1'b0, 8'h63};
        vecs[12] = '{10, 8'hFF, 1'b0, 8'h63};
        vecs[13] = '{12, 8'hFF, 1'b0, 8'h63};
        vecs[14] = '{0,  8'h00, 1'b0, 8'h63};
        vecs[15] = '{14, 8'h00, 1'b0, 8'h63};
        vecs[16] = '{5,  8'h05, 1'b0, 8'h63};
        vecs[17] = '{15, 8'h05, 1'b0, 8'h63};
        vecs[18] = '{13, 8'h05, 1'b0, 8'h63};
        vecs[19] = '{10, 8'hFF, 1'b1, 8'h05};
        vecs[20] = '{-1, 8'hFF, 1'b0, 8'h05};

        RST_N     = 1'b0;
        mask      = 16'h0;
        money_ack = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_col", {4'b0, col}, 8'h01);
        check("rst_money", money_out, 8'hFF);
        check("rst_valid", {7'b0, money_valid}, 8'h00);
        check("rst_entry", entry, 8'hFF);
        RST_N = 1'b1;

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].key < 0) pulse_ack();
            else tap_key(vecs[i].key);
            check($sformatf("vec%0d_entry", i), entry, vecs[i].e_entry);
            check($sformatf("vec%0d_valid", i), {7'b0, money_valid}, {7'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_money", i), money_out, vecs[i].e_money);
        end

        // Long hold: exactly one event (a repeat would show as 77).
        align();
        mask = kmask(7);
        repeat (320) @(posedge CLK);
        #1 mask = 16'h0;
        repeat (48) @(posedge CLK);
        #1;
        check("hold7_entry", entry, 8'h07);
        tap_key(11);
        check("hold7_clear", entry, 8'hFF);

        // Single-frame glitch, then two simultaneous keys: no event.
        align();
        mask = kmask(5);
        repeat (16) @(posedge CLK);
        #1 mask = 16'h0;
        repeat (48) @(posedge CLK);
        #1;
        check("glitch5_entry", entry, 8'hFF);
        align();
        mask = kmask(1) | kmask(2);
        repeat (80) @(posedge CLK);
        #1 mask = 16'h0;
        repeat (48) @(posedge CLK);
        #1;
        check("double_entry", entry, 8'hFF);

        // Ack coinciding with a key event in WAIT_ACK drops the key.
        tap_key(1);
        tap_key(10);
        check("wa_valid", {7'b0, money_valid}, 8'h01);
        check("wa_money", money_out, 8'h01);
        align();
        mask = kmask(8);
        got  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge CLK);
            #1;
            if (dut.press) begin
                money_ack = 1'b1;
                @(posedge CLK);
                #1 money_ack = 1'b0;
                got = 1'b1;
                break;
            end
        end
        check("wa_event_seen", {7'b0, got}, 8'h01);
        check("wa_ack_valid", {7'b0, money_valid}, 8'h00);
        check("wa_ack_entry", entry, 8'hFF);
        mask = 16'h0;
        repeat (48) @(posedge CLK);
        #1;
        check("wa_key_dropped", entry, 8'hFF);
        tap_key(6);
        check("wa_next_entry", entry, 8'h06);
        tap_key(11);
        check("wa_next_clear", entry, 8'hFF);

        // Randomized keys and acks against the reference model.
        m_digits.delete();
        m_wait  = 1'b0;
        m_money = 8'h01;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                pulse_ack();
                m_ack();
            end else begin
                k = $urandom_range(0, 15);
                tap_key(k);
                m_press(k);
            end
            check($sformatf("rnd%0d_entry", i), entry, m_entry());
            check($sformatf("rnd%0d_valid", i), {7'b0, money_valid}, {7'b0, m_wait});
            check($sformatf("rnd%0d_money", i), money_out, m_money);
        end
        if (m_wait) begin
            pulse_ack();
            m_ack();
        end
        tap_key(11);
        check("pre_rst_entry", entry, 8'hFF);

        // Asynchronous reset in the middle of an entry.
        tap_key(9);
        tap_key(10);
        pulse_ack();
        tap_key(3);
        check("mid_entry", entry, 8'h03);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        check("mid_rst_col", {4'b0, col}, 8'h01);
        check("mid_rst_money", money_out, 8'hFF);
        check("mid_rst_valid", {7'b0, money_valid}, 8'h00);
        check("mid_rst_entry", entry, 8'hFF);
        #12 RST_N = 1'b1;

        // Partial entry timeout (only when the feature is built in).
        tap_key(3);
        check("tmo_entry", entry, 8'h03);
        repeat (40) @(posedge CLK);
        #1;
        check("tmo_early", entry, 8'h03);
        repeat (60) @(posedge CLK);
        #1;
`ifdef KEYPAD_TIMEOUT_EN
        check("tmo_late", entry, 8'hFF);
`else
        check("tmo_late", entry, 8'h03);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
